// File: rtl/axi_stream_input_mb.sv
// axi_stream_input_mb: multi-lane AXI-Stream loader routing packets to NUM_BUFFERS SRAMs with shape metadata.
module axi_stream_input_mb #(
    parameter int DATA_WIDTH         = 8,
    parameter int LANES              = 4,
    parameter int ADDR_WIDTH         = 13,
    parameter int NUM_CHANNELS_WIDTH = 7,
    parameter int NUM_BUFFERS        = 4,
    parameter int BUF_IDX_WIDTH      = 2,
    parameter int BUF_DEPTH          = 8192,
    parameter int MAX_ADDR_WIDTH     = 13
) (
    input  logic                                           s_axis_aclk,
    input  logic                                           s_axis_areset,
    input  logic [LANES*DATA_WIDTH-1:0]                    s_axis_tdata,
    input  logic [LANES-1:0]                               s_axis_tkeep,
    input  logic                                           s_axis_tvalid,
    output logic                                           s_axis_tready,
    input  logic                                           s_axis_tlast,
    input  logic [BUF_IDX_WIDTH+2*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
    input  logic                                           sram_ready,
    output logic                                           write_enable,
    output logic [BUF_IDX_WIDTH-1:0]                       write_buf,
    output logic [MAX_ADDR_WIDTH-1:0]                      write_address,
    output logic [LANES*DATA_WIDTH-1:0]                    write_data,
    output logic [LANES-1:0]                               write_mask,
    output logic                                           meta_valid,
    output logic [BUF_IDX_WIDTH-1:0]                       meta_buf,
    output logic [ADDR_WIDTH-1:0]                          meta_rows,
    output logic [ADDR_WIDTH-1:0]                          meta_cols,
    output logic [NUM_CHANNELS_WIDTH-1:0]                  meta_channels,
    output logic [MAX_ADDR_WIDTH:0]                        meta_count,
    output logic                                           overflow_err,
    input  logic                                           err_clear
);
    localparam int UW = BUF_IDX_WIDTH + 2*ADDR_WIDTH + NUM_CHANNELS_WIDTH;
    localparam int MW = MAX_ADDR_WIDTH;
    localparam logic [BUF_IDX_WIDTH:0] NB = (BUF_IDX_WIDTH+1)'(NUM_BUFFERS);
    localparam logic [MW:0]   LN = (MW+1)'(LANES);
    localparam logic [MW+1:0] DP = (MW+2)'(BUF_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_t;
    state_t state_q, state_d;

    logic [BUF_IDX_WIDTH-1:0]      pbuf_q, wbuf_q, mbuf_q;
    logic [MW:0]                   addr_q, cnt_q, mcnt_q;
    logic [MW-1:0]                 waddr_q;
    logic [LANES*DATA_WIDTH-1:0]   wdata_q;
    logic [LANES-1:0]              wmask_q;
    logic                          we_q, mv_q, err_q;
    logic [ADDR_WIDTH-1:0]         mrows_q, mcols_q;
    logic [NUM_CHANNELS_WIDTH-1:0] mch_q;

    logic                     idle, live, acc, bad, wr;
    logic [BUF_IDX_WIDTH-1:0] tu_buf, buf_sel;
    logic [MW:0]              base, cbase, pop;

    assign idle          = state_q == ST_IDLE;
    assign live          = state_q != ST_DROP;
    assign s_axis_tready = live ? sram_ready : 1'b1;
    assign acc           = s_axis_tvalid & s_axis_tready;
    assign tu_buf        = s_axis_tuser[UW-1 -: BUF_IDX_WIDTH];
    assign buf_sel       = idle ? tu_buf : pbuf_q;
    assign base          = idle ? '0 : addr_q;
    assign cbase         = idle ? '0 : cnt_q;
    assign pop           = (MW+1)'($countones(s_axis_tkeep));
    // A packet is bad if its first beat names a missing buffer or a beat would run past the SRAM end.
    assign bad = live & ((idle & ({1'b0, tu_buf} >= NB)) | (({1'b0, base} + {1'b0, LN}) > DP));
    assign wr  = acc & live & ~bad;

    always_comb begin
        state_d = state_q;
        if (acc) state_d = s_axis_tlast ? ST_IDLE : (!live || bad) ? ST_DROP : ST_RECV;
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q <= ST_IDLE;
            pbuf_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wbuf_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            mv_q    <= 1'b0;
            mbuf_q  <= '0;
            mrows_q <= '0;
            mcols_q <= '0;
            mch_q   <= '0;
            mcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= wr;
            mv_q    <= wr & s_axis_tlast;
            err_q   <= (acc & bad) | (err_q & ~err_clear);
            if (acc & live) begin
                addr_q <= base + LN;
                cnt_q  <= cbase + pop;
            end
            if (acc & idle) pbuf_q <= tu_buf;
            if (wr) begin
                wbuf_q  <= buf_sel;
                waddr_q <= base[MW-1:0];
                wdata_q <= s_axis_tdata;
                wmask_q <= s_axis_tkeep;
            end
            if (wr & s_axis_tlast) begin
                mbuf_q  <= buf_sel;
                mrows_q <= s_axis_tuser[2*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1 -: ADDR_WIDTH];
                mcols_q <= s_axis_tuser[ADDR_WIDTH+NUM_CHANNELS_WIDTH-1 -: ADDR_WIDTH];
                mch_q   <= s_axis_tuser[NUM_CHANNELS_WIDTH-1:0];
                mcnt_q  <= cbase + pop;
            end
        end
    end

    assign write_enable  = we_q;
    assign write_buf     = wbuf_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign write_mask    = wmask_q;
    assign meta_valid    = mv_q;
    assign meta_buf      = mbuf_q;
    assign meta_rows     = mrows_q;
    assign meta_cols     = mcols_q;
    assign meta_channels = mch_q;
    assign meta_count    = mcnt_q;
    assign overflow_err  = err_q;
endmodule

// File: doc/axi_stream_input_mb.md
Name: axi_stream_input_mb

Overview:
- Parametrised successor to the NPU's AXI-Stream input loader.
- Accepts multi-lane beats (LANES elements per beat) with TKEEP byte-lane masking.
- Routes each packet to one of NUM_BUFFERS on-chip SRAMs, chosen by a TUSER field; packet order does not fix the destination.
- Applies real back-pressure from the SRAM side, detects buffer overflow, and publishes per-packet shape metadata (rows, cols, channels, element count) to the downstream compute scheduler.

Parameters:
- DATA_WIDTH, 8, bits per element.
- LANES, 4, elements per AXIS beat.
- ADDR_WIDTH, 13, width of row/col shape fields.
- NUM_CHANNELS_WIDTH, 7, width of channel-count field ($clog2(64+1)).
- NUM_BUFFERS, 4, number of destination SRAMs.
- BUF_IDX_WIDTH, 2, $clog2(NUM_BUFFERS).
- BUF_DEPTH, 8192, elements per destination SRAM.
- MAX_ADDR_WIDTH, 13, $clog2(BUF_DEPTH).

Ports:
- s_axis_aclk  in  1  clock
- s_axis_areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  LANES*DATA_WIDTH  signed elements; lane 0 in LSBs
- s_axis_tkeep  in  LANES  per-lane valid
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- s_axis_tlast  in  1  last beat of packet
- s_axis_tuser  in  BUF_IDX_WIDTH+2*ADDR_WIDTH+NUM_CHANNELS_WIDTH  {buf_idx, rows, cols, channels}, MSB to LSB
- sram_ready  in  1  SRAM side can take a write this cycle
- write_enable  out  1  SRAM write strobe
- write_buf  out  BUF_IDX_WIDTH  target SRAM
- write_address  out  MAX_ADDR_WIDTH  element address of lane 0
- write_data  out  LANES*DATA_WIDTH  beat data
- write_mask  out  LANES  per-lane write enable (= registered tkeep)
- meta_valid  out  1  one-cycle pulse when packet metadata is valid
- meta_buf  out  BUF_IDX_WIDTH  buffer the packet went to
- meta_rows  out  ADDR_WIDTH  rows
- meta_cols  out  ADDR_WIDTH  cols
- meta_channels  out  NUM_CHANNELS_WIDTH  channels
- meta_count  out  MAX_ADDR_WIDTH+1  elements written, i.e. popcount of tkeep over written beats
- overflow_err  out  1  sticky error
- err_clear  in  1  clears overflow_err

Behaviour:
- Reset: state=ST_IDLE; every output register, address counter and element counter = 0.
- Handshake:
  - s_axis_tready = sram_ready in ST_IDLE and ST_RECV; s_axis_tready = 1 in ST_DROP.
  - Accept = tvalid & tready. tdata/tkeep/tuser/tlast are sampled only on accept.
- FSM:
  - ST_IDLE: on accept, latch buf_idx from tuser.
    - If buf_idx >= NUM_BUFFERS: no write, set overflow_err, go ST_DROP (stay ST_IDLE if tlast).
    - Else: write the beat at address 0; go ST_RECV, or stay ST_IDLE if tlast.
  - ST_RECV: each accept writes at address_counter.
    - tlast accepted -> ST_IDLE.
    - Beat whose base address + LANES > BUF_DEPTH: suppressed (no write_enable), overflow_err set, -> ST_DROP; if it is also tlast -> ST_IDLE.
  - ST_DROP: consume beats without writing until tlast accepted -> ST_IDLE. No meta_valid for a dropped packet.
- Write path, 1-cycle latency: on a written accept, next cycle write_enable=1 with write_buf / write_address / write_data / write_mask from that beat. Otherwise write_enable=0 and the data/address registers hold.
- Addressing:
  - address_counter starts at 0 for each packet and advances by LANES per accepted beat regardless of tkeep.
  - A partial tkeep mask is legal on any beat.
  - The counter does not wrap; crossing BUF_DEPTH is the overflow condition above.
- Metadata:
  - On a written tlast accept: latch rows/cols/channels from that beat's tuser, meta_buf = packet buf_idx, meta_count = running popcount including this beat.
  - meta_valid pulses the same cycle as the last write_enable.
  - meta_* hold until the next packet completes.
- overflow_err: set by any overflow or illegal buf_idx event; cleared by err_clear. Set wins if both occur in the same cycle.
- Back-to-back packets: a tlast accept followed next cycle by a new first beat is accepted with no bubble; that new beat writes at address 0.
- sram_ready low mid-packet: tready low, counters hold, no write.
- Reset mid-packet: immediate return to ST_IDLE with all outputs zero; the partial packet produces no metadata.

Test Plan:
- Defaults with LANES=4, BUF_DEPTH=16. Packet to buf 2: 3 beats, tkeep 1111,1111,0011, tuser rows=2 cols=5 ch=1 -> writes at addr 0,4,8 to buf 2, last write_mask=0011; meta_valid one cycle with count=10, rows=2, cols=5, ch=1.
- Same packet with sram_ready low for 3 cycles after beat 1 -> tready low for those cycles, no write, then addr 4,8 resume; meta identical.
- 5-beat packet to buf 0 (BUF_DEPTH=16) -> beats 0-3 written; beat 4 suppressed; overflow_err=1; no meta_valid. err_clear pulse -> overflow_err=0.
- First beat with buf_idx=3 while NUM_BUFFERS=3 -> no writes for the whole packet; overflow_err=1; tready stays 1 through tlast.
- Two back-to-back 1-beat packets (buf 1 then buf 0) -> both written at addr 0 on consecutive cycles, two meta_valid pulses; then assert s_axis_areset mid-way through a 3-beat packet -> all outputs 0 and the next packet starts at addr 0.
